cla_carry_sum_pipe: RTL and testbench

Pipelined carry-lookahead and sum stage that sits directly downstream of `gp_gen` in the 64-bit CLA datapath. It consumes per-bit generate/propagate vectors and a carry-in, and forms 4-bit group generate/propagate terms. It then resolves all internal carries by a second-level lookahead across groups and produces the registered sum, carry-out and signed overflow. A valid/ready elastic handshake is used on both sides, so the adder can sit in a back-pressured datapath.

---
 rtl/cla_carry_sum_pipe.sv | 156 +++++++++++++++
 tb/tb_cla_carry_sum_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_carry_sum_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cla_carry_sum_pipe
//  Purpose  : Group/second-level carry lookahead and sum stage with elastic
//             valid/ready handshake; CLA_MID_REG_EN adds the mid (S1) register.
//  Revision : 1.0  initial release
// ============================================================================
module cla_carry_sum_pipe #(
    parameter int DATA_WIDTH  = 64,
    parameter int GROUP_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] g_i,
    input  logic [DATA_WIDTH-1:0] p_i,
    input  logic                  c_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  c_o,
    output logic                  ovf_o
);

    localparam int NUM_GROUPS = DATA_WIDTH / GROUP_WIDTH;

    logic [NUM_GROUPS-1:0] w_in_gg;
    logic [NUM_GROUPS-1:0] w_in_gp;

    logic [DATA_WIDTH-1:0] w_s_g;
    logic [DATA_WIDTH-1:0] w_s_p;
    logic                  w_s_c;
    logic [NUM_GROUPS-1:0] w_s_gg;
    logic [NUM_GROUPS-1:0] w_s_gp;
    logic                  w_s_v;

    logic                  w_en2;
    logic [DATA_WIDTH:0]   w_c;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_co;
    logic                  w_ovf;

    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_co;
    logic                  r_ovf;

    // First-level group generate/propagate from the per-bit terms.
    always_comb begin : p_group_gp
        logic v_g;
        logic v_p;
        w_in_gg = '0;
        w_in_gp = '0;
        for (int j = 0; j < NUM_GROUPS; j++) begin
            v_g = 1'b0;
            v_p = 1'b1;
            for (int b = 0; b < GROUP_WIDTH; b++) begin
                v_g = g_i[j*GROUP_WIDTH+b] | (p_i[j*GROUP_WIDTH+b] & v_g);
                v_p = v_p & p_i[j*GROUP_WIDTH+b];
            end
            w_in_gg[j] = v_g;
            w_in_gp[j] = v_p;
        end
    end

    assign w_en2 = ~r_v2 | ready_i;

`ifdef CLA_MID_REG_EN
    logic                  w_en1;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_s1_g;
    logic [DATA_WIDTH-1:0] r_s1_p;
    logic                  r_s1_c;
    logic [NUM_GROUPS-1:0] r_s1_gg;
    logic [NUM_GROUPS-1:0] r_s1_gp;

    assign w_en1   = ~r_v1 | w_en2;
    assign ready_o = w_en1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1    <= 1'b0;
            r_s1_g  <= '0;
            r_s1_p  <= '0;
            r_s1_c  <= 1'b0;
            r_s1_gg <= '0;
            r_s1_gp <= '0;
        end else if (w_en1) begin
            r_v1    <= valid_i;
            r_s1_g  <= g_i;
            r_s1_p  <= p_i;
            r_s1_c  <= c_i;
            r_s1_gg <= w_in_gg;
            r_s1_gp <= w_in_gp;
        end
    end

    assign w_s_g  = r_s1_g;
    assign w_s_p  = r_s1_p;
    assign w_s_c  = r_s1_c;
    assign w_s_gg = r_s1_gg;
    assign w_s_gp = r_s1_gp;
    assign w_s_v  = r_v1;
`else
    assign ready_o = w_en2;
    assign w_s_g   = g_i;
    assign w_s_p   = p_i;
    assign w_s_c   = c_i;
    assign w_s_gg  = w_in_gg;
    assign w_s_gp  = w_in_gp;
    assign w_s_v   = valid_i;
`endif

    // Group carries hop across groups via G/P; bit carries ripple only inside a group.
    always_comb begin : p_carry
        logic v_gc;
        logic v_bc;
        w_c  = '0;
        v_gc = w_s_c;
        for (int j = 0; j < NUM_GROUPS; j++) begin
            v_bc = v_gc;
            for (int b = 0; b < GROUP_WIDTH; b++) begin
                w_c[j*GROUP_WIDTH+b] = v_bc;
                v_bc = w_s_g[j*GROUP_WIDTH+b] | (w_s_p[j*GROUP_WIDTH+b] & v_bc);
            end
            v_gc = w_s_gg[j] | (w_s_gp[j] & v_gc);
        end
        w_c[DATA_WIDTH] = v_gc;
    end

    assign w_sum = w_s_p ^ w_c[DATA_WIDTH-1:0];
    assign w_co  = w_c[DATA_WIDTH];
    assign w_ovf = w_c[DATA_WIDTH] ^ w_c[DATA_WIDTH-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v2  <= 1'b0;
            r_sum <= '0;
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_en2) begin
            r_v2  <= w_s_v;
            r_sum <= w_sum;
            r_co  <= w_co;
            r_ovf <= w_ovf;
        end
    end

    assign valid_o = r_v2;
    assign sum_o   = r_sum;
    assign c_o     = r_co;
    assign ovf_o   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_carry_sum_pipe.sv
`default_nettype none
// Testbench for cla_carry_sum_pipe: vector table, backpressure, streaming and
// mid-operation reset, with a queue-based scoreboard of expected results.
module tb_cla_carry_sum_pipe;

`ifdef CLA_MID_REG_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [63:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [63:0] g;
        logic [63:0] p;
        logic        c;
        exp_t        e;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] g_i;
    logic [63:0] p_i;
    logic        c_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] sum_o;
    logic        c_o;
    logic        ovf_o;

    exp_t d_exp;
    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    cla_carry_sum_pipe #(.DATA_WIDTH(64), .GROUP_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .g_i(g_i), .p_i(p_i), .c_i(c_i), .valid_o(valid_o), .ready_i(ready_i),
        .sum_o(sum_o), .c_o(c_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_add(input logic [63:0] x, input logic [63:0] y, input logic c);
        logic [64:0] s;
        exp_t        e;
        s     = {1'b0, x} + {1'b0, y} + {64'd0, c};
        e.sum = s[63:0];
        e.co  = s[64];
        e.ovf = (x[63] == y[63]) && (s[63] != x[63]);
        return e;
    endfunction

    // Observes both handshakes mid-cycle, when inputs and outputs are settled.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (valid_o && ready_i) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output actual=%h expected=none", sum_o);
                    end else begin
                        e = q.pop_front();
                        chk("sum_o", sum_o, e.sum);
                        chk("c_o", {63'd0, c_o}, {63'd0, e.co});
                        chk("ovf_o", {63'd0, ovf_o}, {63'd0, e.ovf});
                        n_out++;
                    end
                end
                if (valid_i && ready_o) q.push_back(d_exp);
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [63:0] g, input logic [63:0] p, input logic c, input exp_t e);
        int k;
        g_i = g; p_i = p; c_i = c; d_exp = e; valid_i = 1'b1;
        k = 0;
        @(negedge clk_i);
        while (!ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (!ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout actual=ready_o=0 expected=ready_o=1");
        end
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 50) begin
            @(posedge clk_i);
            k++;
        end
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid_o"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_sum_o"}, sum_o, 64'd0);
        chk({tag, "_c_o"}, {63'd0, c_o}, 64'd0);
        chk({tag, "_ovf_o"}, {63'd0, ovf_o}, 64'd0);
        chk({tag, "_ready_o"}, {63'd0, ready_o}, 64'd1);
    endtask

    task automatic run();
        vec_t        tbl[6];
        vec_t        bp[3];
        logic [63:0] x, y;
        logic        c;
        int          base;
        int          k;

        tbl[0] = '{g: 64'h1, p: 64'hFFFF_FFFF_FFFF_FFFE, c: 1'b0,
                   e: '{sum: 64'h0, co: 1'b1, ovf: 1'b0}};
        tbl[1] = '{g: 64'h1, p: 64'h7FFF_FFFF_FFFF_FFFE, c: 1'b0,
                   e: '{sum: 64'h8000_0000_0000_0000, co: 1'b0, ovf: 1'b1}};
        tbl[2] = '{g: 64'h0, p: 64'hFFFF_FFFF_FFFF_FFFF, c: 1'b1,
                   e: '{sum: 64'h0, co: 1'b1, ovf: 1'b0}};
        tbl[3] = '{g: 64'h8000_0000_0000_0000, p: 64'h0, c: 1'b0,
                   e: '{sum: 64'h0, co: 1'b1, ovf: 1'b1}};
        tbl[4] = '{g: 64'hFFFF_FFFF_FFFF_FFFF, p: 64'h0, c: 1'b0,
                   e: '{sum: 64'hFFFF_FFFF_FFFF_FFFE, co: 1'b1, ovf: 1'b0}};
        tbl[5] = '{g: 64'h0, p: 64'h0, c: 1'b1,
                   e: '{sum: 64'h1, co: 1'b0, ovf: 1'b0}};

        // Reset, with a valid presented during reset that must be dropped.
        rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        g_i = 64'h5; p_i = 64'hA; c_i = 1'b1; d_exp = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0; valid_i = 1'b0;
        check_idle_outputs("reset");

        // Table vectors, back to back.
        foreach (tbl[i]) send(tbl[i].g, tbl[i].p, tbl[i].c, tbl[i].e);
        drain();

        // Backpressure: fill to capacity, check hold, then release.
        for (int i = 0; i < 3; i++) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom}; c = 1'($urandom);
            bp[i] = '{g: x & y, p: x ^ y, c: c, e: ref_add(x, y, c)};
        end
        @(posedge clk_i);
        #1 ready_i = 1'b0;
        base = n_out;
        for (int i = 0; i < CAP; i++) send(bp[i].g, bp[i].p, bp[i].c, bp[i].e);
        g_i = bp[CAP].g; p_i = bp[CAP].p; c_i = bp[CAP].c; d_exp = bp[CAP].e; valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk("bp_ready_o", {63'd0, ready_o}, 64'd0);
            chk("bp_valid_o", {63'd0, valid_o}, 64'd1);
            chk("bp_hold_sum", sum_o, bp[0].e.sum);
        end
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        k = 0;
        @(negedge clk_i);
        while (!ready_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        chk("bp_release_ready", {63'd0, ready_o}, 64'd1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        for (int i = CAP + 1; i < 3; i++) send(bp[i].g, bp[i].p, bp[i].c, bp[i].e);
        drain();
        chk("bp_count", 64'(n_out - base), 64'd3);

        // Full throughput: one result per cycle.
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom}; c = 1'($urandom);
            g_i = x & y; p_i = x ^ y; c_i = c; d_exp = ref_add(x, y, c); valid_i = 1'b1;
            @(negedge clk_i);
            if (i % 25 == 0) chk("tp_ready_o", {63'd0, ready_o}, 64'd1);
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        repeat (LAT - 1) @(posedge clk_i);
        @(negedge clk_i);
        #1 chk("tp_count", 64'(n_out - base), 64'd100);
        drain();

        // Mid-operation reset with the pipe full.
        @(posedge clk_i);
        #1 ready_i = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom};
            send(x & y, x ^ y, 1'b0, ref_add(x, y, 1'b0));
        end
        rst_i = 1'b1; valid_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0; valid_i = 1'b0;
        q.delete();
        base = n_out;
        check_idle_outputs("midrst");
        ready_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1 chk("midrst_no_stale", 64'(n_out - base), 64'd0);
    endtask

    initial begin
        fork
            monitor();
            run();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
